// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS channel encoder: 8b data -> 10b transition-minimised, DC-balanced
// character, or 2b control -> 10b token during blanking. One register stage.
module tmds_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       disp_en,
  input  logic [1:0] ctrl,
  input  logic [7:0] data,
  output logic [9:0] tmds
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  logic [9:0]        tmds_q, tmds_d;
  logic signed [4:0] cnt_q,  cnt_d;

  logic [3:0]        n1d, n1;
  logic              use_xnor;
  logic [8:0]        q_m;
  logic signed [5:0] diff;     // n1 - n0 of q_m[7:0]
  logic signed [5:0] cnt_ext, cnt_nx;
  logic [9:0]        tok;

  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, data[i]};
  end

  assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);

  always_comb begin
    q_m    = 9'd0;
    q_m[0] = data[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
    q_m[8] = ~use_xnor;
  end

  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, q_m[i]};
  end

  // n1 - n0 == 2*n1 - 8
  assign diff    = $signed({1'b0, n1, 1'b0}) - 6'sd8;
  assign cnt_ext = {cnt_q[4], cnt_q};

  always_comb begin
    case (ctrl)
      2'b00:   tok = TOK_00;
      2'b01:   tok = TOK_01;
      2'b10:   tok = TOK_10;
      default: tok = TOK_11;
    endcase
  end

  always_comb begin
    tmds_d = tok;
    cnt_nx = 6'sd0;
    if (disp_en) begin
      if ((cnt_q == 5'sd0) || (n1 == 4'd4)) begin
        tmds_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_nx = q_m[8] ? (cnt_ext + diff) : (cnt_ext - diff);
      end else if (((cnt_q > 5'sd0) && (n1 > 4'd4)) ||
                   ((cnt_q < 5'sd0) && (n1 < 4'd4))) begin
        tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
        cnt_nx = cnt_ext - diff + (q_m[8] ? 6'sd2 : 6'sd0);
      end else begin
        tmds_d = {1'b0, q_m[8], q_m[7:0]};
        cnt_nx = cnt_ext + diff - (q_m[8] ? 6'sd0 : 6'sd2);
      end
    end
    cnt_d = cnt_nx[4:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmds_q <= TOK_00;
      cnt_q  <= 5'sd0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and randomized checks of tmds_encoder against hand-computed vectors,
// an independent behavioural model and a character decoder.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       disp_en = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [7:0] data = 8'h00;
  logic [9:0] tmds;

  int n_chk = 0;
  int n_err = 0;
  int m_cnt = 0;

  tmds_encoder dut (
    .clk(clk), .reset(reset), .disp_en(disp_en),
    .ctrl(ctrl), .data(data), .tmds(tmds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs[9:0], exp[9:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model written from the DVI encoding rules, integer arithmetic.
  function automatic logic [9:0] model(input logic de, input logic [1:0] c,
                                       input logic [7:0] d, inout int cnt);
    int ones_d, ones_q, zeros_q;
    logic [8:0] q;
    logic [9:0] r;
    if (!de) begin
      cnt = 0;
      case (c)
        2'd0: return 10'b1101010100;
        2'd1: return 10'b0010101011;
        2'd2: return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    ones_d = 0;
    foreach (d[i]) ones_d += int'(d[i]);
    q[0] = d[0];
    if (ones_d > 4 || (ones_d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ~^ d[i];
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
      q[8] = 1'b1;
    end
    ones_q = 0;
    for (int i = 0; i < 8; i++) ones_q += int'(q[i]);
    zeros_q = 8 - ones_q;
    if (cnt == 0 || ones_q == zeros_q) begin
      r[9] = ~q[8]; r[8] = q[8];
      r[7:0] = q[8] ? q[7:0] : ~q[7:0];
      cnt = q[8] ? cnt + ones_q - zeros_q : cnt + zeros_q - ones_q;
    end else if ((cnt > 0 && ones_q > zeros_q) || (cnt < 0 && zeros_q > ones_q)) begin
      r = {1'b1, q[8], ~q[7:0]};
      cnt = cnt + (q[8] ? 2 : 0) + zeros_q - ones_q;
    end else begin
      r = {1'b0, q[8], q[7:0]};
      cnt = cnt + ones_q - zeros_q - (q[8] ? 0 : 2);
    end
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] t);
    logic [7:0] v, o;
    v = t[9] ? ~t[7:0] : t[7:0];
    o[0] = v[0];
    for (int i = 1; i < 8; i++) o[i] = t[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    return o;
  endfunction

  initial begin
    logic [1:0]  cv [4];
    logic [9:0]  tv [4];
    logic [9:0]  exp;
    int          d;

    // reset and idle blanking
    #3 reset = 1'b0;
    #1 chk("reset_async", tmds, 10'b1101010100);
    tick();
    chk("reset_held", tmds, 10'b1101010100);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ctrl00", tmds, 10'b1101010100);
    end

    // control tokens
    cv = '{2'b00, 2'b01, 2'b10, 2'b11};
    tv = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    for (int i = 0; i < 4; i++) begin
      ctrl = cv[i];
      tick();
      chk("ctrl_token", tmds, tv[i]);
    end
    ctrl = 2'b00;

    // 0x00 run from cnt=0
    tick();
    disp_en = 1'b1; data = 8'h00;
    tick(); chk("zero_1", tmds, 10'b0100000000);
    tick(); chk("zero_2", tmds, 10'b1111111111);
    tick(); chk("zero_3", tmds, 10'b0100000000);

    // 0xFF pair from cnt=0
    disp_en = 1'b0;
    tick();
    disp_en = 1'b1; data = 8'hFF;
    tick(); chk("ff_1", tmds, 10'b1000000000);
    tick(); chk("ff_2", tmds, 10'b0011111111);

    // blanking clears disparity
    disp_en = 1'b0;
    tick();
    disp_en = 1'b1; data = 8'h00;
    tick(); chk("blank_a", tmds, 10'b0100000000);
    disp_en = 1'b0;
    tick(); chk("blank_tok", tmds, 10'b1101010100);
    disp_en = 1'b1;
    tick(); chk("blank_b", tmds, 10'b0100000000);

    // random run against the model and decoder, reset mid-stream
    disp_en = 1'b0;
    tick();
    m_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        reset = 1'b0;
        #1 chk("reset_midrun", tmds, 10'b1101010100);
        m_cnt = 0;
        reset = 1'b1;
      end
      d       = $urandom_range(0, 15);
      disp_en = (d != 0);
      ctrl    = 2'($urandom_range(0, 3));
      data    = 8'($urandom_range(0, 255));
      exp     = model(disp_en, ctrl, data, m_cnt);
      tick();
      chk("rand_char", tmds, exp);
      if (disp_en) chk("rand_decode", decode(tmds), data);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
